// File: rtl/control_unit.sv
// Multi-cycle sequencer for the processor datapath: fetches from a registered
// instruction ROM, holds PC/IR, and decodes the IR into datapath controls.
//
// state  | meaning
// INIT   | post-reset idle, one cycle before the first fetch
// FETCH  | IR <= ROM data, PC <= PC + 1
// DECODE | select the execute state from IR[15:12]
// NOOP   | no datapath activity
// LOAD_A | data memory read cycle
// LOAD_B | memory data written back into the register file
// STORE  | register port A written to data memory
// ADD    | Ra + Rb written back
// SUB    | Ra - Rb written back
// HALT   | frozen until reset
module control_unit #(
  parameter int PC_WIDTH = 7
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [15:0]         IR_data,
  output logic [PC_WIDTH-1:0] PC_addr,
  output logic [15:0]         IR_out,
  output logic [3:0]          state_out,
  output logic [7:0]          D_addr,
  output logic                D_wr,
  output logic                RF_s,
  output logic [3:0]          RF_W_addr,
  output logic                RF_W_wr,
  output logic [3:0]          RF_Ra_addr,
  output logic                RF_Ra_rd,
  output logic [3:0]          RF_Rb_addr,
  output logic                RF_Rb_rd,
  output logic [2:0]          Alu_s0
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        S_INIT:  state <= S_FETCH;
        S_FETCH: begin
          ir    <= IR_data;
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (ir[15:12])
            4'h1:    state <= S_STORE;
            4'h2:    state <= S_LOAD_A;
            4'h3:    state <= S_ADD;
            4'h4:    state <= S_SUB;
            4'h5:    state <= S_HALT;
            default: state <= S_NOOP;
          endcase
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  assign PC_addr   = pc;
  assign IR_out    = ir;
  assign state_out = state;

  // Controls depend only on registered state/IR, so reset clears them at once.
  always_comb begin
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_wr    = 1'b0;
    RF_Ra_addr = '0;
    RF_Ra_rd   = 1'b0;
    RF_Rb_addr = '0;
    RF_Rb_rd   = 1'b0;
    Alu_s0     = 3'b000;
    case (state)
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = ir[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir[3:0];
        RF_W_wr   = (state == S_LOAD_B);
      end
      S_STORE: begin
        D_addr     = ir[7:0];
        RF_Ra_addr = ir[11:8];
        RF_Ra_rd   = 1'b1;
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir[11:8];
        RF_Rb_addr = ir[7:4];
        RF_Ra_rd   = 1'b1;
        RF_Rb_rd   = 1'b1;
        Alu_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
        RF_W_addr  = ir[3:0];
        RF_W_wr    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed ROM programs push expected
// per-cycle output snapshots; a monitor pops and compares them each cycle.
module tb_control_unit;

  logic        Clock = 1'b1;
  logic        Reset;
  logic [15:0] IR_data;
  logic [6:0]  PC_addr;
  logic [15:0] IR_out;
  logic [3:0]  state_out;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_wr;
  logic [3:0]  RF_Ra_addr;
  logic        RF_Ra_rd;
  logic [3:0]  RF_Rb_addr;
  logic        RF_Rb_rd;
  logic [2:0]  Alu_s0;

  control_unit #(.PC_WIDTH(7)) dut (
    .Clock(Clock), .Reset(Reset), .IR_data(IR_data), .PC_addr(PC_addr),
    .IR_out(IR_out), .state_out(state_out), .D_addr(D_addr), .D_wr(D_wr),
    .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
    .RF_Ra_addr(RF_Ra_addr), .RF_Ra_rd(RF_Ra_rd), .RF_Rb_addr(RF_Rb_addr),
    .RF_Rb_rd(RF_Rb_rd), .Alu_s0(Alu_s0)
  );

  always #5 Clock = ~Clock;

  logic [15:0] rom [128];
  always @(posedge Clock) IR_data <= rom[PC_addr];

  int wr_count = 0;
  always @(posedge Clock) if (D_wr === 1'b1) wr_count++;

  typedef struct packed {
    logic [3:0]  st;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  w_addr;
    logic        w_wr;
    logic [3:0]  ra;
    logic        ra_rd;
    logic [3:0]  rb;
    logic        rb_rd;
    logic [2:0]  alu;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  event  sample_ev;

  function automatic snap_t mk(logic [3:0] st, logic [6:0] pc, logic [15:0] ir);
    snap_t s;
    s    = '0;
    s.st = st;
    s.pc = pc;
    s.ir = ir;
    return s;
  endfunction

  task automatic push(snap_t s, string nm);
    exp_q.push_back(s);
    name_q.push_back(nm);
  endtask

  always begin
    snap_t e, a;
    string nm;
    @(negedge Clock or sample_ev);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = {state_out, PC_addr, IR_out, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
           RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, Alu_s0};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got st=%0d pc=%0d snap=%h, want st=%0d pc=%0d snap=%h",
                    nm, a.st, a.pc, a, e.st, e.pc, e);
    end
  end

  // Returns just after a falling edge once every queued expectation is consumed.
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge Clock);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic check_int(string nm, int got, int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  initial begin
    snap_t s;
    Reset = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

    // All-NOOP program: reset values, first steps, and PC wrap 127 -> 0
    for (int i = 0; i < 3; i++) push(mk(0, 0, 0), "reset_hold");
    drain();
    Reset = 1'b1;
    for (int i = 0; i <= 128; i++) begin
      push(mk(1, 7'(i), 0), "noop_fetch");
      push(mk(2, 7'(i + 1), 0), "noop_decode");
      push(mk(3, 7'(i + 1), 0), "noop_exec");
    end
    drain();
    check_int("noop_no_writes", wr_count, 0);

    // LOAD, ADD, STORE, SUB, HALT program
    Reset = 1'b0;
    rom[0] = 16'h201A;
    rom[1] = 16'h3A9B;
    rom[2] = 16'h1B1F;
    rom[3] = 16'h4BA2;
    rom[4] = 16'h5000;
    push(mk(0, 0, 0), "reset_b0");
    push(mk(0, 0, 0), "reset_b1");
    drain();
    Reset = 1'b1;
    push(mk(1, 0, 0), "fetch_load");
    push(mk(2, 1, 16'h201A), "decode_load");
    s = mk(4, 1, 16'h201A); s.d_addr = 8'h01; s.rf_s = 1'b1; s.w_addr = 4'hA;
    push(s, "load_a");
    s.st = 5; s.w_wr = 1'b1;
    push(s, "load_b");
    push(mk(1, 1, 16'h201A), "fetch_add");
    push(mk(2, 2, 16'h3A9B), "decode_add");
    s = mk(7, 2, 16'h3A9B); s.ra = 4'hA; s.ra_rd = 1'b1; s.rb = 4'h9; s.rb_rd = 1'b1;
    s.alu = 3'b001; s.w_addr = 4'hB; s.w_wr = 1'b1;
    push(s, "add_exec");
    push(mk(1, 2, 16'h3A9B), "fetch_store");
    push(mk(2, 3, 16'h1B1F), "decode_store");
    s = mk(6, 3, 16'h1B1F); s.d_addr = 8'h1F; s.ra = 4'hB; s.ra_rd = 1'b1; s.d_wr = 1'b1;
    push(s, "store_exec");
    push(mk(1, 3, 16'h1B1F), "fetch_sub");
    push(mk(2, 4, 16'h4BA2), "decode_sub");
    s = mk(8, 4, 16'h4BA2); s.ra = 4'hB; s.ra_rd = 1'b1; s.rb = 4'hA; s.rb_rd = 1'b1;
    s.alu = 3'b010; s.w_addr = 4'h2; s.w_wr = 1'b1;
    push(s, "sub_exec");
    push(mk(1, 4, 16'h4BA2), "fetch_halt");
    push(mk(2, 5, 16'h5000), "decode_halt");
    for (int i = 0; i < 20; i++) push(mk(9, 5, 16'h5000), "halt_hold");
    drain();
    check_int("prog_store_writes", wr_count, 1);

    // Reset out of HALT, then reset asserted in the middle of a STORE
    Reset = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1B1F;
    rom[1] = 16'h7FFF;
    push(mk(0, 0, 0), "halt_reset0");
    push(mk(0, 0, 0), "halt_reset1");
    drain();
    Reset = 1'b1;
    push(mk(1, 0, 0), "fetch_st2");
    push(mk(2, 1, 16'h1B1F), "decode_st2");
    s = mk(6, 1, 16'h1B1F); s.d_addr = 8'h1F; s.ra = 4'hB; s.ra_rd = 1'b1; s.d_wr = 1'b1;
    push(s, "store_before_reset");
    drain();
    Reset = 1'b0;
    push(mk(0, 0, 0), "store_reset_immediate");
    #1;
    -> sample_ev;
    #1;
    push(mk(0, 0, 0), "store_reset_hold");
    drain();
    check_int("aborted_store_no_write", wr_count, 1);
    Reset = 1'b1;
    push(mk(1, 0, 0), "fetch_st3");
    push(mk(2, 1, 16'h1B1F), "decode_st3");
    push(s, "store_exec3");
    push(mk(1, 1, 16'h1B1F), "fetch_op7");
    push(mk(2, 2, 16'h7FFF), "decode_op7");
    push(mk(3, 2, 16'h7FFF), "op7_as_noop");
    push(mk(1, 2, 16'h7FFF), "fetch_after_op7");
    drain();
    check_int("completed_store_write", wr_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle controller that sequences the processor datapath: the data memory, the write-back mux, the 16-entry register file and the ALU. It owns the program counter (PC) and the instruction register (IR), fetches 16-bit instructions from a synchronous instruction ROM, and decodes them. It then drives every datapath control input for one instruction at a time. It sits between the instruction ROM and the datapath, and its debug outputs drive the board displays.

## Interface
- PC_WIDTH, 7, program counter / ROM address width
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- IR_data  in  16  instruction ROM output; ROM is registered, so data is valid one cycle after PC_addr changes
- PC_addr  out  PC_WIDTH  instruction ROM address (= PC register)
- IR_out  out  16  current IR contents (debug)
- state_out  out  4  current state encoding (debug)
- D_addr  out  8  data memory address
- D_wr  out  1  data memory write enable
- RF_s  out  1  write-back mux select: 0 = ALU result, 1 = data memory q
- RF_W_addr  out  4  register file write address
- RF_W_wr  out  1  register file write enable
- RF_Ra_addr  out  4  register file port A address
- RF_Ra_rd  out  1  port A read enable
- RF_Rb_addr  out  4  register file port B address
- RF_Rb_rd  out  1  port B read enable
- Alu_s0  out  3  ALU function: 000 pass/zero, 001 add (A+B), 010 sub (A−B)

## Operation
- Instruction format, opcode = IR[15:12]:
  - 0000 NOOP
  - 0001 STORE: mem[IR[7:0]] ← R[IR[11:8]]
  - 0010 LOAD: R[IR[3:0]] ← mem[IR[11:4]]
  - 0011 ADD: R[IR[3:0]] ← R[IR[11:8]] + R[IR[7:4]]
  - 0100 SUB: same fields as ADD, A−B
  - 0101 HALT
  - 0110–1111: treated as NOOP
- States and encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Transitions:
  - INIT → FETCH → DECODE → {NOOP | LOAD_A | STORE | ADD | SUB | HALT} by opcode.
  - LOAD_A → LOAD_B → FETCH.
  - NOOP, STORE, ADD and SUB → FETCH.
  - HALT → HALT until Reset.
- FETCH: IR ← IR_data; PC ← PC+1 (mod 2^PC_WIDTH; 127 wraps to 0).
- Default outputs in every state: all enables 0, all addresses 0, RF_s 0, Alu_s0 000. Each state overrides only what it lists below.
- LOAD_A: D_addr=IR[11:4]; RF_s=1; RF_W_addr=IR[3:0]. This is the memory read cycle.
- LOAD_B: same as LOAD_A plus RF_W_wr=1.
- STORE: D_addr=IR[7:0]; RF_Ra_addr=IR[11:8]; RF_Ra_rd=1; D_wr=1.
- ADD: RF_Ra_addr=IR[11:8]; RF_Rb_addr=IR[7:4]; RF_Ra_rd=RF_Rb_rd=1; Alu_s0=001; RF_s=0; RF_W_addr=IR[3:0]; RF_W_wr=1.
- SUB: as ADD with Alu_s0=010.
- All control outputs are a combinational function of state and IR only. IR_data never reaches them directly.

## Timing
- Reset asserted (0): state=INIT, PC=0, IR=0 asynchronously. All control outputs take their default (0) values in the same instant, so a pending D_wr or RF_W_wr is dropped.
- First edge after Reset deasserts: INIT → FETCH. The ROM has presented mem[0] since PC=0.
- Cycles per instruction:
  - NOOP, STORE, ADD, SUB: 3 (FETCH, DECODE, EXEC).
  - LOAD: 4.
  - HALT: 2 to enter, then holds.
- IR updates only on the FETCH edge; it holds through DECODE and EXEC states.
- PC increments only on the FETCH edge. The ROM fetch of the next instruction overlaps DECODE/EXEC.
- Register write and memory write happen on the clock edge that ends the EXEC state (LOAD_B for LOAD).
- In HALT: PC and IR frozen, no enables asserted, state_out=9.

## Test plan
- Reset held low for 3 cycles, then released with ROM[0]=NOOP -> during reset PC_addr=0, IR_out=0, state_out=0, all enables 0; state_out then steps 0,1,2,3,1 and PC_addr reads 1 after the first FETCH.
- ROM[0]=16'h201A (LOAD R10 ← mem[0x01]) -> LOAD_A: D_addr=0x01, RF_s=1; LOAD_B: adds RF_W_wr=1, RF_W_addr=0xA; then FETCH.
- ROM[1]=16'h3A9B (ADD R11 ← R10+R9) -> in state 7: Ra_addr=A, Rb_addr=9, both rd=1, Alu_s0=001, RF_s=0, W_addr=B, W_wr=1 for exactly one cycle.
- ROM[2]=16'h1B1F (STORE mem[0x1F] ← R11), ROM[3]=16'h4BA2 (SUB R2 ← R11−R10) -> STORE: D_wr=1, D_addr=0x1F, Ra_addr=B; SUB: Alu_s0=010, W_addr=2.
- ROM[4]=16'h5000 (HALT), followed by 20 idle cycles -> state_out stays 9, PC_addr stays 5, no enables asserted; Reset pulse returns to state 0 with PC 0.
- PC wrap: ROM filled with NOOP, run 128 instructions -> PC_addr goes 127 → 0. In a separate run, Reset is asserted mid-STORE -> D_wr falls immediately and no write occurs.
